// File: rtl/smem_xbar_if.sv
// Core-side bus of the shared-memory crossbar: per-core load/store requests
// with packed address/data lanes, and per-core completion pulses and read data.
interface smem_xbar_if #(
  parameter int NUM_CORES = 16,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
);
  logic [NUM_CORES-1:0]        read;
  logic [NUM_CORES-1:0]        write;
  logic [NUM_CORES*ADDR_W-1:0] addr_in;
  logic [NUM_CORES*DATA_W-1:0] data_in;
  logic [NUM_CORES*DATA_W-1:0] data_out;
  logic [NUM_CORES-1:0]        finish;
  logic                        busy;

  // The cores side drives requests and consumes completions.
  modport master (
    output read, write, addr_in, data_in,
    input  data_out, finish, busy
  );

  // The crossbar side consumes requests and returns completions.
  modport slave (
    input  read, write, addr_in, data_in,
    output data_out, finish, busy
  );
endinterface

// File: rtl/smem_xbar.sv
// Shared-memory crossbar: NUM_CORES load/store ports onto NUM_BANKS single-port
// banks, word-interleaved on the low address bits. Each bank picks one winner
// per cycle with its own round-robin pointer; with BCAST_EN a read winner also
// serves every other pending read of the same bank row in the same cycle.
module smem_xbar #(
  parameter int NUM_CORES = 16,
  parameter int NUM_BANKS = 16,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BCAST_EN  = 1
) (
  input  logic       clk,
  input  logic       reset,
  smem_xbar_if.slave bus
);
  localparam int BB_RAW = $clog2(NUM_BANKS);
  localparam int BB     = (BB_RAW > 0) ? BB_RAW : 1;
  localparam int ROW_W  = (ADDR_W > BB) ? (ADDR_W - BB) : 1;
  localparam int DEPTH  = 1 << ROW_W;
  localparam int CW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam bit BCAST  = (BCAST_EN != 0);

  genvar gi;

  // Reject geometries the address split cannot express.
  if (NUM_CORES < 2 || NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 ||
      ADDR_W <= BB_RAW) begin : g_param_err
    $error("smem_xbar: illegal parameter set");
  end

  // Index arithmetic modulo NUM_CORES (which need not be a power of two).
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CORES) sum = sum - NUM_CORES;
    return CW'(sum);
  endfunction

  // Per-core decoded request fields.
  logic [BB-1:0]        core_bank  [NUM_CORES];
  logic [ROW_W-1:0]     core_row   [NUM_CORES];
  logic [DATA_W-1:0]    core_wdata [NUM_CORES];
  logic [NUM_CORES-1:0] is_wr;
  logic [NUM_CORES-1:0] is_rd;
  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] served;

  // Per-bank arbitration results.
  logic [NUM_BANKS-1:0] win_valid;
  logic [NUM_BANKS-1:0] win_wr;
  logic [CW-1:0]        win_idx    [NUM_BANKS];
  logic [ROW_W-1:0]     win_row    [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic [CW-1:0]        rr_ptr_reg [NUM_BANKS];

  // Per-core completion state.
  logic [NUM_CORES-1:0] finish_reg;
  logic [NUM_CORES-1:0] rd_fin_reg;
  logic [BB-1:0]        src_bank_reg [NUM_CORES];
  logic [DATA_W-1:0]    hold_reg     [NUM_CORES];

  for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign core_bank[gi]  = bus.addr_in[gi*ADDR_W +: BB];
    assign core_row[gi]   = bus.addr_in[gi*ADDR_W + BB +: ROW_W];
    assign core_wdata[gi] = bus.data_in[gi*DATA_W +: DATA_W];
    // read+write together counts as a write; the read half is dropped.
    assign is_wr[gi]      = bus.write[gi];
    assign is_rd[gi]      = bus.read[gi] & ~bus.write[gi];
    // A core in its finish cycle is masked so its request never runs twice;
    // nothing is pending while reset is held, so no grant can fire in reset.
    assign pending[gi]    = (bus.read[gi] | bus.write[gi]) & ~finish_reg[gi] & reset;
    // Served as the bank winner, or as a read riding on a read winner's row.
    assign served[gi] = pending[gi] & win_valid[core_bank[gi]] &
                        ((win_idx[core_bank[gi]] == CW'(gi)) |
                         (BCAST & is_rd[gi] & ~win_wr[core_bank[gi]] &
                          (core_row[gi] == win_row[core_bank[gi]])));
    // Fresh bank read data in the finish cycle, the held value otherwise.
    assign bus.data_out[gi*DATA_W +: DATA_W] =
        rd_fin_reg[gi] ? bank_rdata[src_bank_reg[gi]] : hold_reg[gi];
  end

  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [NUM_CORES-1:0] req;
    logic                 found;
    logic [CW-1:0]        idx;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    rdata_q;

    // Pending cores whose address maps to this bank.
    always_comb begin
      req = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        req[c] = pending[c] & (core_bank[c] == BB'(gi));
      end
    end

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!found && req[wrap_add(rr_ptr_reg[gi], i)]) begin
          found = 1'b1;
          idx   = wrap_add(rr_ptr_reg[gi], i);
        end
      end
    end

    assign win_valid[gi] = found;
    assign win_idx[gi]   = idx;
    assign win_wr[gi]    = is_wr[idx];
    assign win_row[gi]   = core_row[idx];

    // Single-port bank: the winner either stores or loads at the grant edge.
    always_ff @(posedge clk) begin
      if (found && is_wr[idx]) begin
        mem[core_row[idx]] <= core_wdata[idx];
      end
      if (found && !is_wr[idx]) begin
        rdata_q <= mem[core_row[idx]];
      end
    end

    assign bank_rdata[gi] = rdata_q;
  end

  // Each bank's pointer moves one past its winner; broadcast riders do not move it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr_reg[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (win_valid[b]) rr_ptr_reg[b] <= wrap_add(win_idx[b], 1);
      end
    end
  end

  // Completion pulses, read source tracking and held read data per core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish_reg <= '0;
      rd_fin_reg <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        src_bank_reg[c] <= '0;
        hold_reg[c]     <= '0;
      end
    end else begin
      finish_reg <= served;
      rd_fin_reg <= served & is_rd;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (served[c]) src_bank_reg[c] <= core_bank[c];
        if (rd_fin_reg[c]) hold_reg[c] <= bank_rdata[src_bank_reg[c]];
      end
    end
  end

  assign bus.finish = finish_reg;
  assign bus.busy   = (|pending) | (|finish_reg);
endmodule
